// File: rtl/nnacc_pkg.sv
// Shared accelerator constants: data/sum widths, default column count and
// the IDLE/DRAIN state encoding used by psum_drain.
package nnacc_pkg;
  localparam int DATA_W    = 8;
  localparam int SUM_W     = 32;
  localparam int N_COL_DEF = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
endpackage

// File: rtl/psum_quant.sv
// Combinational requantizer: |sum| with round-half-away, saturate to 127,
// sign-magnitude out. Macro PSUM_DRAIN_RELU_EN forces negative sums to 0x00.
module psum_quant
  import nnacc_pkg::*;
#(
  parameter int SUM_W = nnacc_pkg::SUM_W
) (
  input  logic [SUM_W-1:0]  sum,
  input  logic [4:0]        shift,
  output logic [DATA_W-1:0] q
);

  logic             neg;
  logic [SUM_W:0]   mag;
  logic [SUM_W+1:0] rnd;
  logic [SUM_W+1:0] acc;
  logic [SUM_W+1:0] r_full;
  logic [6:0]       r7;

  always_comb begin
    neg = sum[SUM_W-1];
    // One extra bit so the most negative sum has a representable magnitude.
    mag = neg ? (~{1'b1, sum} + (SUM_W+1)'(1)) : {1'b0, sum};
    rnd = '0;
    if (shift != 5'd0) rnd[shift - 5'd1] = 1'b1;
    acc    = {1'b0, mag} + rnd;
    r_full = acc >> shift;
    r7     = (|r_full[SUM_W+1:7]) ? 7'h7F : r_full[6:0];
`ifdef PSUM_DRAIN_RELU_EN
    q = neg ? '0 : {1'b0, r7};
`else
    q = {neg && (r7 != 7'd0), r7};
`endif
  end

endmodule

// File: rtl/psum_drain.sv
// Snapshots N_COL accumulator sums on cap and drains them one per accepted
// handshake through a shared quantizer. Optional macro: PSUM_DRAIN_RELU_EN.
module psum_drain
  import nnacc_pkg::*;
#(
  parameter int N_COL = nnacc_pkg::N_COL_DEF,
  parameter int SUM_W = nnacc_pkg::SUM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap,
  input  logic [N_COL*SUM_W-1:0]   sum_in,
  input  logic [4:0]               shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(N_COL)-1:0] out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(N_COL);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [4:0]       shift_q;
  logic [SUM_W-1:0] snap [N_COL];
  logic [DATA_W-1:0] q;
  logic             at_last;
  logic             xfer;
  logic             last_xfer;
  logic             load;

  always_comb begin
    busy      = (state == ST_DRAIN);
    at_last   = (idx == IDX_W'(N_COL - 1));
    xfer      = busy && out_ready;
    last_xfer = xfer && at_last;
    // A capture is accepted when idle or exactly on the final transfer.
    load      = cap && (!busy || last_xfer);
  end

  psum_quant #(.SUM_W(SUM_W)) u_quant (
    .sum   (snap[idx]),
    .shift (shift_q),
    .q     (q)
  );

  assign out_valid = busy;
  assign out_data  = busy ? q : '0;
  assign out_idx   = idx;
  assign out_last  = busy && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      shift_q <= '0;
      overrun <= 1'b0;
      for (int unsigned k = 0; k < N_COL; k++) snap[k] <= '0;
    end else begin
      if (load) begin
        for (int unsigned k = 0; k < N_COL; k++) snap[k] <= sum_in[k*SUM_W +: SUM_W];
        shift_q <= shift;
        idx     <= '0;
        state   <= ST_DRAIN;
      end else if (last_xfer) begin
        idx   <= '0;
        state <= ST_IDLE;
      end else if (xfer) begin
        idx <= idx + IDX_W'(1);
      end
      if (cap && busy && !last_xfer) overrun <= 1'b1;
    end
  end

endmodule
